// File: rtl/cla_pkg.sv
// Shared constants and types for the registered 4-bit carry-lookahead adder.
package cla_pkg;

    localparam int unsigned CLA_WIDTH = 4;

    // Per-bit propagate and generate vectors feeding the carry unit.
    typedef struct packed {
        logic [CLA_WIDTH-1:0] p;
        logic [CLA_WIDTH-1:0] g;
    } cla_pg_t;

endpackage

// File: rtl/cla_carry_unit.sv
// Flat two-level lookahead carry logic: every carry is a direct sum of
// products of P, G and C0, so no carry depends on another carry.
module cla_carry_unit
    import cla_pkg::*;
(
    input  logic [CLA_WIDTH-1:0] i_p,
    input  logic [CLA_WIDTH-1:0] i_g,
    input  logic                 i_c0,
    output logic [CLA_WIDTH:1]   o_c
);

    // Sum-of-products carries C1..C4.
    always_comb begin
        o_c[1] = i_g[0]
               | (i_p[0] & i_c0);
        o_c[2] = i_g[1]
               | (i_p[1] & i_g[0])
               | (i_p[1] & i_p[0] & i_c0);
        o_c[3] = i_g[2]
               | (i_p[2] & i_g[1])
               | (i_p[2] & i_p[1] & i_g[0])
               | (i_p[2] & i_p[1] & i_p[0] & i_c0);
        o_c[4] = i_g[3]
               | (i_p[3] & i_g[2])
               | (i_p[3] & i_p[2] & i_g[1])
               | (i_p[3] & i_p[2] & i_p[1] & i_g[0])
               | (i_p[3] & i_p[2] & i_p[1] & i_p[0] & i_c0);
    end

endmodule

// File: rtl/cla_4bit.sv
// Registered 4-bit carry-lookahead adder: {Cout, S} = A + B + C0.
// CLA_INPUT_REG_EN defined: operands are registered first (latency 2).
// CLA_INPUT_REG_EN undefined: ports feed the lookahead logic directly (latency 1).
module cla_4bit
    import cla_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CLA_WIDTH-1:0] A,
    input  logic [CLA_WIDTH-1:0] B,
    input  logic                 C0,
    output logic [CLA_WIDTH-1:0] S,
    output logic                 Cout
);

    logic [CLA_WIDTH-1:0] w_a;
    logic [CLA_WIDTH-1:0] w_b;
    logic                 w_c0;
    cla_pg_t              w_pg;
    logic [CLA_WIDTH:1]   w_c;
    logic [CLA_WIDTH-1:0] w_sum;

    logic [CLA_WIDTH-1:0] r_s;
    logic                 r_cout;

`ifdef CLA_INPUT_REG_EN
    logic [CLA_WIDTH-1:0] r_a;
    logic [CLA_WIDTH-1:0] r_b;
    logic                 r_c0;

    // Operand capture stage; reset wins over capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a  <= '0;
            r_b  <= '0;
            r_c0 <= 1'b0;
        end else begin
            r_a  <= A;
            r_b  <= B;
            r_c0 <= C0;
        end
    end

    assign w_a  = r_a;
    assign w_b  = r_b;
    assign w_c0 = r_c0;
`else
    assign w_a  = A;
    assign w_b  = B;
    assign w_c0 = C0;
`endif

    // Bit-level propagate/generate.
    always_comb begin
        w_pg.p = w_a ^ w_b;
        w_pg.g = w_a & w_b;
    end

    cla_carry_unit u_carry (
        .i_p  (w_pg.p),
        .i_g  (w_pg.g),
        .i_c0 (w_c0),
        .o_c  (w_c)
    );

    // Each sum bit uses the carry into that bit; C0 feeds bit 0.
    always_comb begin
        w_sum = w_pg.p ^ {w_c[CLA_WIDTH-1:1], w_c0};
    end

    // Result stage; reset wins over capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s    <= '0;
            r_cout <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c[CLA_WIDTH];
        end
    end

    assign S    = r_s;
    assign Cout = r_cout;

endmodule

// File: tb/tb_cla_4bit.sv
// Directed self-checking bench for cla_4bit; latency follows CLA_INPUT_REG_EN.
module tb_cla_4bit;

`ifdef CLA_INPUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic       clk;
    logic       reset;
    logic [3:0] A;
    logic [3:0] B;
    logic       C0;
    logic [3:0] S;
    logic       Cout;

    int checks = 0;
    int errors = 0;

    logic [3:0] s_a [0:511];
    logic [3:0] s_b [0:511];
    logic       s_c [0:511];

    cla_4bit dut (
        .clk   (clk),
        .reset (reset),
        .A     (A),
        .B     (B),
        .C0    (C0),
        .S     (S),
        .Cout  (Cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] exp);
        logic [4:0] obs;
        obs = {Cout, S};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] gold(input logic [3:0] a, input logic [3:0] b,
                                        input logic c);
        return {1'b0, a} + {1'b0, b} + {4'b0000, c};
    endfunction

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic c);
        A  = a;
        B  = b;
        C0 = c;
    endtask

    // Feed n operand sets one per cycle and check each at the configured latency.
    task automatic run_stream(input string tag, input int n);
        int idx;
        for (int t = 0; t < n + LAT - 1; t++) begin
            if (t < n) drive(s_a[t], s_b[t], s_c[t]);
            tick();
            idx = t - LAT + 1;
            if (idx >= 0) chk(tag, gold(s_a[idx], s_b[idx], s_c[idx]));
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(4'd13, 4'd7, 1'b1);
        #1;

        // Reset for one edge, then release with operands held.
        tick();
        chk("reset_hold", 5'd0);
        reset = 1'b0;
        repeat (LAT) tick();
        chk("post_reset_21", 5'd21);

        drive(4'd15, 4'd0, 1'b1);
        repeat (LAT) tick();
        chk("prop_chain", 5'd16);

        drive(4'd15, 4'd15, 1'b1);
        repeat (LAT) tick();
        chk("all_ones", 5'd31);

        drive(4'd0, 4'd0, 1'b0);
        repeat (LAT) tick();
        chk("all_zero", 5'd0);

        drive(4'd10, 4'd5, 1'b0);
        repeat (LAT) tick();
        chk("alt_bits", 5'd15);

        // Back-to-back: 7, 16, 16 on consecutive cycles.
        s_a[0] = 4'd3; s_b[0] = 4'd4; s_c[0] = 1'b0;
        s_a[1] = 4'd8; s_b[1] = 4'd8; s_c[1] = 1'b0;
        s_a[2] = 4'd9; s_b[2] = 4'd6; s_c[2] = 1'b1;
        run_stream("b2b", 3);

        // Mid-operation reset discards the in-flight result.
        drive(4'd5, 4'd5, 1'b0);
        tick();
        reset = 1'b1;
        drive(4'd1, 4'd2, 1'b0);
        tick();
        chk("mid_reset", 5'd0);
        reset = 1'b0;
        tick();
        chk("after_reset_1", (LAT == 1) ? 5'd3 : 5'd0);
        repeat (LAT - 1) tick();
        chk("after_reset_op", 5'd3);

        // Exhaustive sweep of all {A, B, C0}.
        for (int i = 0; i < 512; i++) begin
            s_a[i] = 4'(i >> 5);
            s_b[i] = 4'(i >> 1);
            s_c[i] = i[0];
        end
        run_stream("sweep", 512);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
